// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and width helpers for the unified memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Transaction FSM: one access walks IDLE -> ACCESS -> WAIT -> RESP -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Owner of the in-flight transaction
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Latency timer width: must hold MEM_LATENCY-1, never narrower than 1 bit
    function automatic int LAT_W(input int mem_latency);
        return (mem_latency <= 2) ? 1 : $clog2(mem_latency);
    endfunction

    // Starvation counter width: must hold 0..STARVE_LIMIT
    function automatic int STV_W(input int starve_limit);
        return $clog2(starve_limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter_if
// Description : Fetch port, data port and RAM port of the unified arbiter.
//               slave = arbiter view, master = core + RAM view.
// Revision    : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    // Load/store data port
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    // Single-port RAM
    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    // Status
    logic                  busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter_lat_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_lat_timer
// Description : Loadable down-counter timing the RAM read latency.
//               done_o is high whenever the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_lat_timer #(
    parameter int LAT_W    = 1,
    parameter int LOAD_VAL = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load_i,
    input  wire logic en_i,
    output logic      done_o
);
    logic [LAT_W-1:0] r_cnt_q;
    logic [LAT_W-1:0] w_cnt_d;

    // Load takes precedence; otherwise count down to zero and hold there
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (load_i) begin
            w_cnt_d = LAT_W'(LOAD_VAL);
        end else if (en_i && (r_cnt_q != '0)) begin
            w_cnt_d = r_cnt_q - LAT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign done_o = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-port synchronous RAM between the fetch port
//               and the load/store port. Data port has priority; a starvation
//               counter forces a fetch grant after STARVE_LIMIT data grants.
//               One transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    unified_mem_arbiter_if.slave   bus
);
    localparam int c_LAT_W = LAT_W(MEM_LATENCY);
    localparam int c_STV_W = STV_W(STARVE_LIMIT);
    localparam int c_BE_W  = DATA_W / 8;

    state_t                r_state_q, w_state_d;
    logic                  r_owner_q, w_owner_d;
    logic [ADDR_W-1:0]     r_addr_q,  w_addr_d;
    logic                  r_we_q,    w_we_d;
    logic [c_BE_W-1:0]     r_be_q,    w_be_d;
    logic [DATA_W-1:0]     r_wdata_q, w_wdata_d;
    logic [DATA_W-1:0]     r_rdata_q, w_rdata_d;
    logic [c_STV_W-1:0]    r_starve_q, w_starve_d;

    logic w_idle;
    logic w_starved;
    logic w_if_gnt;
    logic w_d_gnt;
    logic w_lat_done;

    assign w_idle    = (r_state_q == ST_IDLE);
    assign w_starved = (r_starve_q == c_STV_W'(STARVE_LIMIT));

    // Grants are combinational and only in IDLE; gated by rst so that every
    // output is zero while reset is held
    assign w_d_gnt  = !rst && w_idle && bus.d_req && !(bus.if_req && w_starved);
    assign w_if_gnt = !rst && w_idle && bus.if_req && (!bus.d_req || w_starved);

    mem_arb_lat_timer #(
        .LAT_W    (c_LAT_W),
        .LOAD_VAL (MEM_LATENCY - 1)
    ) u_lat_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (r_state_q == ST_ACCESS),
        .en_i   (r_state_q == ST_WAIT),
        .done_o (w_lat_done)
    );

    // Command latch, starvation counter and read-data capture next state
    always_comb begin
        w_owner_d  = r_owner_q;
        w_addr_d   = r_addr_q;
        w_we_d     = r_we_q;
        w_be_d     = r_be_q;
        w_wdata_d  = r_wdata_q;
        w_rdata_d  = r_rdata_q;
        w_starve_d = r_starve_q;
        if (w_d_gnt) begin
            w_owner_d = OWN_D;
            w_addr_d  = bus.d_addr;
            w_we_d    = bus.d_we;
            // Reads always fetch the whole word
            w_be_d    = bus.d_we ? bus.d_be : {c_BE_W{1'b1}};
            w_wdata_d = bus.d_wdata;
            if (!bus.if_req) begin
                w_starve_d = '0;
            end else if (!w_starved) begin
                w_starve_d = r_starve_q + c_STV_W'(1);
            end
        end else if (w_if_gnt) begin
            w_owner_d  = OWN_IF;
            w_addr_d   = bus.if_addr;
            w_we_d     = 1'b0;
            w_be_d     = {c_BE_W{1'b1}};
            w_wdata_d  = '0;
            w_starve_d = '0;
        end
        if ((r_state_q == ST_WAIT) && w_lat_done) begin
            w_rdata_d = bus.mem_rdata;
        end
    end

    // Next-state and output decode; everything defaults to zero
    always_comb begin
        w_state_d     = r_state_q;
        bus.if_gnt    = w_if_gnt;
        bus.d_gnt     = w_d_gnt;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = !w_idle;
        case (r_state_q)
            ST_IDLE: begin
                if (w_if_gnt || w_d_gnt) begin
                    w_state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = r_we_q;
                bus.mem_be    = r_be_q;
                bus.mem_addr  = r_addr_q;
                bus.mem_wdata = r_wdata_q;
                w_state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_lat_done) begin
                    w_state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (r_owner_q == OWN_IF) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = r_rdata_q;
                end else begin
                    bus.d_rvalid  = 1'b1;
                    // Write acknowledges carry no data
                    bus.d_rdata   = r_we_q ? '0 : r_rdata_q;
                end
                w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Command, capture and starvation registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_q  <= OWN_IF;
            r_addr_q   <= '0;
            r_we_q     <= 1'b0;
            r_be_q     <= '0;
            r_wdata_q  <= '0;
            r_rdata_q  <= '0;
            r_starve_q <= '0;
        end else begin
            r_owner_q  <= w_owner_d;
            r_addr_q   <= w_addr_d;
            r_we_q     <= w_we_d;
            r_be_q     <= w_be_d;
            r_wdata_q  <= w_wdata_d;
            r_rdata_q  <= w_rdata_d;
            r_starve_q <= w_starve_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Directed, table-driven bench for unified_mem_arbiter with a
//               latency-2 byte-enabled RAM model preloaded mem[i] = i*4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MEM_LATENCY  (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: writes merge by byte enable, reads appear 2 cycles after mem_en
    logic [31:0] ram [256];
    logic [31:0] pipe0, pipe1;
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'(i * 4);
    end
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) ram[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
        pipe0 <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr[9:2]] : 32'h0;
        pipe1 <= pipe0;
    end
    assign bus.mem_rdata = pipe1;

    // Activity counters sampled on the falling edge
    int n_if_rv = 0, n_d_rv = 0, n_if_gnt = 0;
    always @(negedge clk) begin
        if (bus.if_rvalid) n_if_rv <= n_if_rv + 1;
        if (bus.d_rvalid)  n_d_rv  <= n_d_rv + 1;
        if (bus.if_gnt)    n_if_gnt <= n_if_gnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ir;  logic [31:0] ia;
        logic        dr;  logic dw; logic [3:0] db; logic [31:0] da; logic [31:0] dwd;
        logic        eig; logic eirv; logic [31:0] eird;
        logic        edg; logic edrv; logic [31:0] edrd;
        logic        emen; logic emwe; logic [3:0] embe; logic [31:0] ema; logic [31:0] emwd;
        logic        ebusy;
    } vec_t;

    function automatic vec_t row(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [3:0] db, input logic [31:0] da, input logic [31:0] dwd,
        input logic eig, input logic eirv, input logic [31:0] eird,
        input logic edg, input logic edrv, input logic [31:0] edrd,
        input logic emen, input logic emwe, input logic [3:0] embe, input logic [31:0] ema,
        input logic [31:0] emwd, input logic ebusy);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.db = db; v.da = da; v.dwd = dwd;
        v.eig = eig; v.eirv = eirv; v.eird = eird; v.edg = edg; v.edrv = edrv; v.edrd = edrd;
        v.emen = emen; v.emwe = emwe; v.embe = embe; v.ema = ema; v.emwd = emwd; v.ebusy = ebusy;
        return v;
    endfunction

    // Busy cycle with nothing visible on the outputs
    function automatic vec_t brow(input logic ir, input logic [31:0] ia);
        return row(ir, ia, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1);
    endfunction

    function automatic logic [159:0] act_pack();
        return {21'b0, bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.busy};
    endfunction

    function automatic logic [159:0] exp_pack(input vec_t v);
        return {21'b0, v.eig, v.eirv, v.eird, v.edg, v.edrv, v.edrd,
                v.emen, v.emwe, v.embe, v.ema, v.emwd, v.ebusy};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_idle();
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 30) begin
            next_cycle();
            settle();
            n++;
        end
        check(name, 160'(bus.busy), 160'(0));
    endtask

    vec_t vecs [31];
    int   who [6];
    int   at  [6];
    int   g, cyc, rv0, ig0;

    initial begin
        int n = 0;
        // Test 1: lone fetch of 0x10
        vecs[n++] = row(1, 32'h10, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h10, 0, 1);
        vecs[n++] = brow(0, 0);
        vecs[n++] = brow(0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1);
        // Test 2: simultaneous requests, data first then fetch
        vecs[n++] = row(1, 32'h14, 1, 0, 4'hF, 32'h20, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[n++] = row(1, 32'h14, 0, 0, 4'hF, 32'h20, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h20, 0, 1);
        vecs[n++] = brow(1, 32'h14);
        vecs[n++] = brow(1, 32'h14);
        vecs[n++] = row(1, 32'h14, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0, 4'h0, 0, 0, 1);
        vecs[n++] = row(1, 32'h14, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h14, 0, 1);
        vecs[n++] = brow(0, 0);
        vecs[n++] = brow(0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h14, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1);
        // Test 4: partial write to 0x8 then read back the merged word
        vecs[n++] = row(0, 0, 1, 1, 4'h3, 32'h8, 32'hAABBCCDD, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'h3, 32'h8, 32'hAABBCCDD, 1);
        vecs[n++] = brow(0, 0);
        vecs[n++] = brow(0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 1);
        vecs[n++] = row(0, 0, 1, 0, 4'hF, 32'h8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h8, 0, 1);
        vecs[n++] = brow(0, 0);
        vecs[n++] = brow(0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'h0000CCDD, 0, 0, 4'h0, 0, 0, 1);
        // Write with no byte enables still makes one access with mem_be = 0
        vecs[n++] = row(0, 0, 1, 1, 4'h0, 32'hC, 32'h12345678, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'h0, 32'hC, 32'h12345678, 1);
        vecs[n++] = brow(0, 0);
        vecs[n++] = brow(0, 0);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 1);
        vecs[n++] = row(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);

        // Reset state
        drive_idle();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", act_pack(), 160'(0));
        rst = 0;

        // Table-driven vectors
        for (int i = 0; i < n; i++) begin
            next_cycle();
            bus.if_req = vecs[i].ir; bus.if_addr = vecs[i].ia;
            bus.d_req = vecs[i].dr; bus.d_we = vecs[i].dw; bus.d_be = vecs[i].db;
            bus.d_addr = vecs[i].da; bus.d_wdata = vecs[i].dwd;
            settle();
            check($sformatf("vec%0d", i), act_pack(), exp_pack(vecs[i]));
        end

        // Test 3: starvation guard with both requests held high
        next_cycle();
        bus.if_req = 1; bus.if_addr = 32'h44;
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h40; bus.d_wdata = 0;
        for (int k = 0; k < 6; k++) begin who[k] = -1; at[k] = 0; end
        g = 0; cyc = 0;
        while (g < 6 && cyc < 100) begin
            settle();
            if (bus.if_gnt || bus.d_gnt) begin
                who[g] = bus.if_gnt ? 1 : 0;
                at[g]  = cyc;
                g++;
            end
            next_cycle();
            cyc++;
        end
        drive_idle();
        settle();
        check("starve_grant_count", 160'(g), 160'(6));
        for (int k = 0; k < 6; k++)
            check($sformatf("starve_owner%0d", k), 160'(who[k]), 160'((k == 4) ? 1 : 0));
        for (int k = 1; k < 6; k++)
            check($sformatf("starve_spacing%0d", k), 160'(at[k] - at[k-1]), 160'(5));
        wait_idle("starve_idle");

        // Test 5: reset while in WAIT abandons the access
        next_cycle();
        bus.if_req = 1; bus.if_addr = 32'h30;
        settle();
        check("rst_first_gnt", 160'(bus.if_gnt), 160'(1));
        rv0 = n_if_rv + n_d_rv;
        next_cycle();
        bus.if_req = 0;
        next_cycle();
        rst = 1;
        #1;
        check("rst_async_outputs", act_pack(), 160'(0));
        repeat (3) next_cycle();
        check("rst_held_outputs", act_pack(), 160'(0));
        rst = 0;
        bus.if_req = 1; bus.if_addr = 32'h34;
        settle();
        check("rst_no_rvalid", 160'(n_if_rv + n_d_rv - rv0), 160'(0));
        check("rst_release_gnt", 160'(bus.if_gnt), 160'(1));
        next_cycle();
        bus.if_req = 0;
        repeat (3) next_cycle();
        settle();
        check("rst_new_rvalid", {127'b0, bus.if_rvalid, bus.if_rdata}, {127'b0, 1'b1, 32'h34});
        next_cycle();
        settle();
        check("rst_rvalid_count", 160'(n_if_rv + n_d_rv - rv0), 160'(1));

        // Test 6: one-cycle fetch pulse while busy is ignored
        ig0 = n_if_gnt;
        rv0 = n_if_rv;
        next_cycle();
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF; bus.d_addr = 32'h50;
        settle();
        check("pulse_d_gnt", 160'(bus.d_gnt), 160'(1));
        next_cycle();
        bus.d_req = 0;
        bus.if_req = 1; bus.if_addr = 32'h60;
        settle();
        check("pulse_no_gnt", 160'(bus.if_gnt), 160'(0));
        next_cycle();
        bus.if_req = 0;
        repeat (2) next_cycle();
        settle();
        check("pulse_d_rvalid", {127'b0, bus.d_rvalid, bus.d_rdata}, {127'b0, 1'b1, 32'h50});
        repeat (6) next_cycle();
        settle();
        check("pulse_if_gnt_count", 160'(n_if_gnt - ig0), 160'(0));
        check("pulse_if_rvalid_count", 160'(n_if_rv - rv0), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
